// File: rtl/fish_row_fetcher.sv
// Fetches one sprite row per scanline into a double-buffered line buffer and
// serves the pixel under the beam. Optional horizontal flip: FISH_MIRROR_EN.
module fish_row_fetcher #(
    parameter int unsigned            DATA_WIDTH  = 12,
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            SPR_W       = 64,
    parameter int unsigned            SPR_H       = 32,
    parameter int unsigned            FRAMES      = 8,
    parameter logic [DATA_WIDTH-1:0]  TRANSPARENT = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [9:0]            next_y,
    input  logic [9:0]            fish_x,
    input  logic [9:0]            fish_y,
    input  logic [2:0]            frame_idx,
    input  logic [9:0]            pixel_x,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [DATA_WIDTH-1:0] pixel_rgb,
    output logic                  pixel_hit,
    output logic                  busy,
    output logic                  overrun
`ifdef FISH_MIRROR_EN
    ,
    input  logic                  mirror
`endif
);

    localparam int unsigned CW = $clog2(SPR_W);
    localparam int unsigned RW = $clog2(SPR_H);

    if (longint'(FRAMES) * longint'(SPR_W) * longint'(SPR_H) > (longint'(1) << ADDR_WIDTH)) begin : g_fit
        $error("fish_row_fetcher: FRAMES*SPR_W*SPR_H exceeds SRAM address space");
    end

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAIN} state_t;

    state_t                  state_q;
    logic                    front_q;
    logic [1:0]              valid_q;
    logic [9:0]              origin_q [2];
    logic [DATA_WIDTH-1:0]   buf_q    [2][SPR_W];
    logic [9:0]              next_y_q, fish_x_q, fish_y_q;
    logic [2:0]              frame_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic                    sram_en_q, pixel_hit_q, busy_q, overrun_q;
    logic [ADDR_WIDTH-1:0]   sram_addr_q;
    logic [DATA_WIDTH-1:0]   pixel_rgb_q;

    logic                    back_c, in_range_c, look_hit_c, mirror_c;
    logic [10:0]             row_diff_c, dx_c;
    logic [DATA_WIDTH-1:0]   look_word_c;

`ifdef FISH_MIRROR_EN
    logic mirror_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mirror_q <= 1'b0;
        end else if (line_start) begin
            mirror_q <= mirror;
        end
    end

    assign mirror_c = mirror_q;
`else
    assign mirror_c = 1'b0;
`endif

    // Word address of a sprite pixel; wraps through truncation to ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_f(input logic [2:0] fr,
                                                     input logic [RW-1:0] r,
                                                     input logic [CW-1:0] c,
                                                     input logic m);
        logic [CW-1:0] cc;
        logic [31:0]   full;
        cc   = m ? (CW'(SPR_W - 1) - c) : c;
        full = 32'(fr) * 32'(SPR_W * SPR_H) + 32'(r) * 32'(SPR_W) + 32'(cc);
        return ADDR_WIDTH'(full);
    endfunction

    assign back_c      = ~front_q;
    assign row_diff_c  = {1'b0, next_y_q} - {1'b0, fish_y_q};
    assign in_range_c  = row_diff_c < 11'(SPR_H);
    // Negative dx wraps to a large unsigned value and so fails the width test.
    assign dx_c        = {1'b0, pixel_x} - {1'b0, origin_q[front_q]};
    assign look_word_c = buf_q[front_q][dx_c[CW-1:0]];
    assign look_hit_c  = valid_q[front_q] && (dx_c < 11'(SPR_W)) && (look_word_c != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            valid_q     <= 2'b00;
            origin_q[0] <= '0;
            origin_q[1] <= '0;
            next_y_q    <= '0;
            fish_x_q    <= '0;
            fish_y_q    <= '0;
            frame_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
            pixel_rgb_q <= '0;
            pixel_hit_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            pixel_hit_q <= look_hit_c;
            pixel_rgb_q <= look_hit_c ? look_word_c : '0;

            if (line_start) begin
                // An unfinished fetch leaves its buffer invalid before the swap.
                if (state_q != IDLE) begin
                    overrun_q        <= 1'b1;
                    valid_q[back_c]  <= 1'b0;
                end
                front_q   <= ~front_q;
                next_y_q  <= next_y;
                fish_x_q  <= fish_x;
                fish_y_q  <= fish_y;
                frame_q   <= frame_idx;
                sram_en_q <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= CHECK;
            end else begin
                case (state_q)
                    CHECK: begin
                        valid_q[back_c] <= 1'b0;
                        if (in_range_c) begin
                            origin_q[back_c] <= fish_x_q;
                            row_q            <= row_diff_c[RW-1:0];
                            col_q            <= '0;
                            sram_en_q        <= 1'b1;
                            sram_addr_q      <= addr_f(frame_q, row_diff_c[RW-1:0], '0, mirror_c);
                            state_q          <= FETCH;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    FETCH: begin
                        // Data for the column issued last cycle is on sram_data now.
                        if (col_q != '0) begin
                            buf_q[back_c][col_q - CW'(1)] <= sram_data;
                        end
                        if (col_q == CW'(SPR_W - 1)) begin
                            sram_en_q <= 1'b0;
                            state_q   <= DRAIN;
                        end else begin
                            col_q       <= col_q + CW'(1);
                            sram_addr_q <= addr_f(frame_q, row_q, col_q + CW'(1), mirror_c);
                        end
                    end
                    DRAIN: begin
                        buf_q[back_c][SPR_W-1] <= sram_data;
                        valid_q[back_c]        <= 1'b1;
                        busy_q                 <= 1'b0;
                        state_q                <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sram_en   = sram_en_q;
    assign sram_addr = sram_addr_q;
    assign pixel_rgb = pixel_rgb_q;
    assign pixel_hit = pixel_hit_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fish_row_fetcher.sv
// Scoreboard bench for fish_row_fetcher: expected SRAM addresses and pixel
// lookups are queued by the stimulus and checked by an independent monitor.
module tb_fish_row_fetcher;

    logic        clk = 1'b0;
    logic        reset, line_start;
    logic [9:0]  next_y, fish_x, fish_y, pixel_x;
    logic [2:0]  frame_idx;
    logic        sram_en, pixel_hit, busy, overrun;
    logic [15:0] sram_addr;
    logic [11:0] sram_data, pixel_rgb;
`ifdef FISH_MIRROR_EN
    logic        mirror = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          px;
        logic        hit;
        logic [11:0] rgb;
    } pix_t;

    logic [15:0] addr_exp [$];
    pix_t        pix_exp  [$];
    logic        look_v = 1'b0;
    logic        look_d = 1'b0;

    always #5 clk = ~clk;

    fish_row_fetcher dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_y(next_y),
        .fish_x(fish_x), .fish_y(fish_y), .frame_idx(frame_idx), .pixel_x(pixel_x),
        .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
        .pixel_rgb(pixel_rgb), .pixel_hit(pixel_hit), .busy(busy), .overrun(overrun)
`ifdef FISH_MIRROR_EN
        , .mirror(mirror)
`endif
    );

    // Sprite SRAM contents; address 6470 holds the colour key.
    function automatic logic [11:0] mem_f(input logic [15:0] a);
        logic [15:0] t;
        if (a == 16'd6470) return 12'h0F0;
        t = a * 16'd5 + 16'd7;
        return t[11:0] ^ 12'h300;
    endfunction

    always @(posedge clk) begin
        if (sram_en) sram_data <= mem_f(sram_addr);
        look_d <= look_v;
    end

    // Monitor: consumes expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        logic [15:0] a;
        pix_t        p;
        if (sram_en) begin
            checks++;
            if (addr_exp.size() == 0) begin
                errors++;
                $display("FAIL sram_addr_unexpected actual=%0d required=no_fetch", sram_addr);
            end else begin
                a = addr_exp.pop_front();
                if (sram_addr !== a) begin
                    errors++;
                    $display("FAIL sram_addr actual=%0d required=%0d", sram_addr, a);
                end
            end
        end
        if (look_d) begin
            checks++;
            p = pix_exp.pop_front();
            if (pixel_hit !== p.hit || pixel_rgb !== p.rgb) begin
                errors++;
                $display("FAIL pixel_x=%0d actual hit=%0b rgb=%h required hit=%0b rgb=%h",
                         p.px, pixel_hit, pixel_rgb, p.hit, p.rgb);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input int ny);
        next_y     = 10'(ny);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic push_addrs(input int base, input int n);
        for (int i = 0; i < n; i++) addr_exp.push_back(16'(base + i));
    endtask

    task automatic lookup(input int px, input logic hit, input logic [11:0] rgb);
        pix_t p;
        p.px = px; p.hit = hit; p.rgb = rgb;
        pix_exp.push_back(p);
        pixel_x = 10'(px);
        look_v  = 1'b1;
        @(negedge clk);
        look_v  = 1'b0;
    endtask

    task automatic count_cycles(input int n, output int busy_n, output int ovr_n);
        busy_n = 0;
        ovr_n  = 0;
        for (int i = 0; i < n; i++) begin
            busy_n += int'(busy);
            ovr_n  += int'(overrun);
            @(negedge clk);
        end
    endtask

    initial begin
        int b, o, b2, o2;
        reset = 1'b1; line_start = 1'b0; next_y = '0; pixel_x = '0;
        fish_x = 10'd200; fish_y = 10'd100; frame_idx = 3'd3;
        repeat (3) @(negedge clk);
        check("reset_sram_en", int'(sram_en), 0);
        check("reset_sram_addr", int'(sram_addr), 0);
        check("reset_pixel_rgb", int'(pixel_rgb), 0);
        check("reset_pixel_hit", int'(pixel_hit), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset while column 20 is on the bus.
        push_addrs(6464, 21);
        pulse(105);
        repeat (21) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_sram_en", int'(sram_en), 0);
        check("midreset_busy", int'(busy), 0);
        reset = 1'b0;
        lookup(200, 1'b0, 12'h000);
        lookup(230, 1'b0, 12'h000);
        pulse(300);
        repeat (3) @(negedge clk);
        lookup(200, 1'b0, 12'h000);
        lookup(263, 1'b0, 12'h000);

        // Full fetch of frame 3, row 5.
        push_addrs(6464, 64);
        pulse(105);
        count_cycles(70, b, o);
        check("fetch_busy_cycles", b, 66);
        check("fetch_overrun", o, 0);
        pulse(300);
        count_cycles(3, b, o);
        check("nofetch_busy_cycles", b, 1);
        lookup(199, 1'b0, 12'h000);
        lookup(200, 1'b1, mem_f(16'd6464));
        lookup(205, 1'b1, mem_f(16'd6469));
        lookup(206, 1'b0, 12'h000);
        lookup(263, 1'b1, mem_f(16'd6527));
        lookup(264, 1'b0, 12'h000);
        lookup(0, 1'b0, 12'h000);

        // Rows just outside the sprite: no fetch, line shows no sprite.
        pulse(99);
        count_cycles(3, b, o);
        check("row_above_busy_cycles", b, 1);
        lookup(200, 1'b0, 12'h000);
        pulse(132);
        count_cycles(3, b, o);
        check("row_below_busy_cycles", b, 1);
        lookup(200, 1'b0, 12'h000);
        lookup(210, 1'b0, 12'h000);

        // Abort a fetch with line_start 30 cycles after it started.
        push_addrs(6464, 29);
        pulse(105);
        count_cycles(29, b, o);
        push_addrs(6464, 64);
        pulse(105);
        count_cycles(70, b2, o2);
        check("overrun_pulses", o + o2, 1);
        lookup(200, 1'b0, 12'h000);
        pulse(300);
        repeat (2) @(negedge clk);
        lookup(200, 1'b1, mem_f(16'd6464));
        lookup(231, 1'b1, mem_f(16'd6495));

        // Sprite hanging off the right edge still fetches and displays.
        fish_x = 10'd600; frame_idx = 3'd0;
        push_addrs(0, 64);
        pulse(100);
        count_cycles(70, b, o);
        check("edge_busy_cycles", b, 66);
        pulse(300);
        repeat (2) @(negedge clk);
        lookup(639, 1'b1, mem_f(16'd39));
        lookup(599, 1'b0, 12'h000);

        repeat (3) @(negedge clk);
        check("addr_queue_drained", addr_exp.size(), 0);
        check("pix_queue_drained", pix_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
